pll_reset_sequencer: RTL and testbench

//   Consumes the PLL 'locked' output in the PLL output clock domain.

---
 rtl/pll_reset_sequencer_pkg.sv | 18 +
 rtl/pll_reset_sequencer_sync_ff.sv | 34 +++
 rtl/pll_reset_sequencer.sv | 131 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Contents:
//   state_e  - sequencer FSM state encoding
//   max_u    - unsigned max, used to size the qualification counter
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// N-stage synchroniser for a single asynchronous input bit.
// Ports:
//   clock  in   destination-domain clock
//   reset  in   synchronous, active-high; clears every stage
//   d      in   asynchronous input
//   q      out  d delayed through N flops
module pll_reset_sequencer_sync_ff #(
  parameter int unsigned N = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  // Shift in at bit 0; the oldest sample leaves from the top.
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the system in reset until the PLL lock has been stable for a
// qualification period plus a hold period, then releases it. Any loss of
// lock while running re-asserts reset and is recorded for debug.
// Ports:
//   clock       in   PLL output clock; sole clock of the block
//   reset       in   synchronous, active-high
//   locked      in   raw PLL lock, asynchronous to clock
//   clear_lost  in   1-cycle pulse; clears lock_lost and lost_count
//   sys_reset   out  system reset, active-high, registered
//   ready       out  high only in RUN, registered, always ~sys_reset
//   lock_lost   out  sticky flag: lock dropped while in RUN
//   lost_count  out  saturating count of RUN loss events
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned COUNT_WIDTH        = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   locked,
  input  logic                   clear_lost,
  output logic                   sys_reset,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [COUNT_WIDTH-1:0] lost_count
);

  localparam int unsigned CNT_MAX = max_u(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

  logic locked_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   ready_q, ready_d;
  logic                   lock_lost_q, lock_lost_d;
  logic [COUNT_WIDTH-1:0] lost_count_q, lost_count_d;
  logic                   loss_event;

  // Bring the raw lock indication into the clock domain.
  pll_reset_sequencer_sync_ff #(
    .N (SYNC_STAGES)
  ) u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (locked),
    .q     (locked_s)
  );

  // Next-state, counter and output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    loss_event   = 1'b0;
    lock_lost_d  = lock_lost_q;
    lost_count_d = lost_count_q;

    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s)                state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = HOLD;
        else                          cnt_d   = cnt_q + CNT_W'(1);
      end
      HOLD: begin
        if (!locked_s)              state_d = WAIT_LOCK;
        else if (cnt_q == HOLD_LAST) state_d = RUN;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      RUN: begin
        if (!locked_s) begin
          state_d    = WAIT_LOCK;
          loss_event = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // Every phase measures its own duration from zero.
    if (state_d != state_q) cnt_d = '0;

    // Outputs track the state being entered so they switch on the same edge.
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);

    // A loss on the same edge as a clear must still be recorded.
    if (loss_event) begin
      lock_lost_d = 1'b1;
      if (clear_lost)          lost_count_d = COUNT_WIDTH'(1);
      else if (&lost_count_q)  lost_count_d = lost_count_q;
      else                     lost_count_d = lost_count_q + COUNT_WIDTH'(1);
    end else if (clear_lost) begin
      lock_lost_d  = 1'b0;
      lost_count_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
      lost_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sys_reset_q  <= sys_reset_d;
      ready_q      <= ready_d;
      lock_lost_q  <= lock_lost_d;
      lost_count_q <= lost_count_d;
    end
  end

  assign sys_reset  = sys_reset_q;
  assign ready      = ready_q;
  assign lock_lost  = lock_lost_q;
  assign lost_count = lost_count_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer with small qualification times.
module tb_pll_reset_sequencer;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned LSC   = 8;
  localparam int unsigned RHC   = 4;
  localparam int unsigned CW    = 2;
  localparam int unsigned RUN_C = 1 + LSC + RHC;
  localparam int unsigned SAT   = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          locked;
  logic          clear_lost;
  logic          sys_reset;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] lost_count;

  int    total;
  int    bad;
  string phase;

  // Reference model: consecutive synchronised-lock samples, plus loss history.
  bit          pipe[$];
  int unsigned m_c;
  bit          m_lost;
  int unsigned m_cnt;

  typedef struct {
    bit rst;
    bit lk;
    bit clr;
    bit e_sr;
    bit e_rdy;
    bit e_lost;
    int e_cnt;
  } vec_t;

  vec_t tbl[19];

  pll_reset_sequencer #(
    .SYNC_STAGES        (SYNC),
    .LOCK_STABLE_CYCLES (LSC),
    .RESET_HOLD_CYCLES  (RHC),
    .COUNT_WIDTH        (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .locked     (locked),
    .clear_lost (clear_lost),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .lock_lost  (lock_lost),
    .lost_count (lost_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s/%s: got %0d required %0d", phase, name, act, exp);
    end
  endtask

  // Lock is usable once it has been seen on RUN_C consecutive synchronised samples.
  task automatic model_edge(input bit r, input bit lk, input bit clr);
    bit ls;
    bit was_run;
    if (r) begin
      pipe.delete();
      for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);
      m_c    = 0;
      m_lost = 1'b0;
      m_cnt  = 0;
    end else begin
      ls = pipe.pop_front();
      pipe.push_back(lk);
      was_run = (m_c >= RUN_C);
      if (ls) m_c = (m_c < RUN_C) ? m_c + 1 : m_c;
      else    m_c = 0;
      if (was_run && !ls) begin
        m_lost = 1'b1;
        m_cnt  = clr ? 1 : ((m_cnt == SAT) ? SAT : m_cnt + 1);
      end else if (clr) begin
        m_lost = 1'b0;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit lk, input bit clr);
    bit exp_rdy;
    reset      = r;
    locked     = lk;
    clear_lost = clr;
    @(posedge clock);
    model_edge(r, lk, clr);
    #1;
    exp_rdy = (m_c >= RUN_C);
    check("sys_reset", int'(sys_reset), int'(!exp_rdy));
    check("ready", int'(ready), int'(exp_rdy));
    check("lock_lost", int'(lock_lost), int'(m_lost));
    check("lost_count", int'(lost_count), int'(m_cnt));
  endtask

  task automatic run_until_ready(input int budget, output int n);
    n = 0;
    while (!ready && n < budget) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    check("ready_timeout", int'(ready), 1);
  endtask

  // One RUN loss: raw lock low for a single edge, then back high.
  task automatic lose_lock(input bit clr_on_loss);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, clr_on_loss);
  endtask

  initial begin
    int n;
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    locked     = 1'b0;
    clear_lost = 1'b0;
    for (int i = 0; i < SYNC; i++) pipe.push_back(1'b0);

    // Release latency from reset with lock held from edge 1.
    phase  = "latency";
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    for (int i = 1; i < 19; i++)
      tbl[i] = '{1'b0, 1'b1, 1'b0, (i < 15), (i >= 15), 1'b0, 0};
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].lk, tbl[i].clr);
      check("tbl_sys_reset", int'(sys_reset), int'(tbl[i].e_sr));
      check("tbl_ready", int'(ready), int'(tbl[i].e_rdy));
      check("tbl_lock_lost", int'(lock_lost), int'(tbl[i].e_lost));
      check("tbl_lost_count", int'(lost_count), tbl[i].e_cnt);
    end

    // Loss in RUN: reset re-asserts two edges after the low sample.
    phase = "run_loss";
    step(1'b0, 1'b0, 1'b0);
    check("k_sys_reset", int'(sys_reset), 0);
    step(1'b0, 1'b1, 1'b0);
    check("k1_sys_reset", int'(sys_reset), 0);
    step(1'b0, 1'b1, 1'b0);
    check("k2_sys_reset", int'(sys_reset), 1);
    check("k2_ready", int'(ready), 0);
    check("k2_lock_lost", int'(lock_lost), 1);
    check("k2_lost_count", int'(lost_count), 1);
    run_until_ready(40, n);
    check("requal_edges", n, 13);

    // Single-cycle glitch during qualification restarts it without a loss event.
    phase = "glitch";
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check("g_sys_reset", int'(sys_reset), (i < 15) ? 1 : 0);
      check("g_lost_count", int'(lost_count), 0);
    end

    // Loss counter saturates.
    phase = "saturate";
    for (int i = 1; i <= 4; i++) begin
      lose_lock(1'b0);
      check("sat_count", int'(lost_count), (i < 3) ? i : 3);
      check("sat_flag", int'(lock_lost), 1);
      run_until_ready(40, n);
    end

    // Clear coincident with a loss: the loss wins.
    phase = "clear_vs_loss";
    lose_lock(1'b1);
    check("cl_lock_lost", int'(lock_lost), 1);
    check("cl_lost_count", int'(lost_count), 1);
    step(1'b0, 1'b1, 1'b1);
    check("clr_lock_lost", int'(lock_lost), 0);
    check("clr_lost_count", int'(lost_count), 0);

    // Reset during HOLD, then during RUN with loss history present.
    phase = "reset_mid";
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("hold_rst_sys_reset", int'(sys_reset), 1);
    check("hold_rst_ready", int'(ready), 0);
    run_until_ready(40, n);
    check("hold_rst_requal", n, 15);
    lose_lock(1'b0);
    run_until_ready(40, n);
    check("pre_rst_flag", int'(lock_lost), 1);
    step(1'b1, 1'b1, 1'b0);
    check("run_rst_sys_reset", int'(sys_reset), 1);
    check("run_rst_ready", int'(ready), 0);
    check("run_rst_lock_lost", int'(lock_lost), 0);
    check("run_rst_lost_count", int'(lost_count), 0);
    run_until_ready(40, n);
    check("run_rst_requal", n, 15);

    // Randomised traffic against the model.
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 99) < 93),
           ($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
